mips_instr_exec: RTL and testbench

- Single-cycle MIPS-subset execution core.
- Executes one externally supplied 32-bit instruction per clock: decode, register read, ALU, data-memory access and write-back.
- No PC or instruction memory; the surrounding bench or fetch logic drives `instruction` every cycle.
- Write-back, memory and debug ports are exposed for observation.

---
 rtl/mips_instr_exec.sv | 176 +++++++++++++++++
 tb/tb_mips_instr_exec.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_exec.sv
// Single-cycle MIPS-subset core: decode, register file, ALU, flop data memory, write-back.
// Define IMM_LOGIC_EN to add andi/ori/slti/lui; otherwise those opcodes execute as NOPs.
`timescale 1ns/1ps

module mips_instr_exec #(
  parameter int unsigned DMEM_WORDS = 64,
  parameter int unsigned DMEM_AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] alu_result
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
`ifdef IMM_LOGIC_EN
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
`endif

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluLui} alu_op_e;
  typedef enum logic [1:0] {OpbReg, OpbSext, OpbZext} opb_sel_e;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext;

  assign opcode   = instruction[31:26];
  assign rs       = instruction[25:21];
  assign rt       = instruction[20:16];
  assign rd       = instruction[15:11];
  assign funct    = instruction[5:0];
  assign imm      = instruction[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  // Decoded controls
  logic     dec_wr_reg;
  logic     dec_dst_rd;
  logic     dec_mem_rd;
  logic     dec_mem_wr;
  alu_op_e  alu_op;
  opb_sel_e opb_sel;

  always_comb begin
    dec_wr_reg = 1'b0;
    dec_dst_rd = 1'b0;
    dec_mem_rd = 1'b0;
    dec_mem_wr = 1'b0;
    alu_op     = AluAdd;
    opb_sel    = OpbSext;
    unique case (opcode)
      OpRtype: begin
        dec_dst_rd = 1'b1;
        opb_sel    = OpbReg;
        unique case (funct)
          FnAdd:   begin dec_wr_reg = 1'b1; alu_op = AluAdd; end
          FnSub:   begin dec_wr_reg = 1'b1; alu_op = AluSub; end
          FnAnd:   begin dec_wr_reg = 1'b1; alu_op = AluAnd; end
          FnOr:    begin dec_wr_reg = 1'b1; alu_op = AluOr;  end
          FnSlt:   begin dec_wr_reg = 1'b1; alu_op = AluSlt; end
          default: dec_wr_reg = 1'b0;
        endcase
      end
      OpAddi: dec_wr_reg = 1'b1;
      OpLw: begin
        dec_wr_reg = 1'b1;
        dec_mem_rd = 1'b1;
      end
      OpSw: dec_mem_wr = 1'b1;
`ifdef IMM_LOGIC_EN
      OpAndi: begin dec_wr_reg = 1'b1; alu_op = AluAnd; opb_sel = OpbZext; end
      OpOri:  begin dec_wr_reg = 1'b1; alu_op = AluOr;  opb_sel = OpbZext; end
      OpSlti: begin dec_wr_reg = 1'b1; alu_op = AluSlt; end
      OpLui:  begin dec_wr_reg = 1'b1; alu_op = AluLui; end
`endif
      default: dec_wr_reg = 1'b0;
    endcase
  end

  // Register file; entry 0 is never written and always reads as zero
  logic [31:0] rf_q [32];
  logic [31:0] rs_val, rt_val;

  assign rs_val    = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_val    = (rt == 5'd0) ? 32'h0 : rf_q[rt];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'h0 : rf_q[dbg_raddr];

  // ALU
  logic [31:0] opb;

  always_comb begin
    opb = imm_sext;
    unique case (opb_sel)
      OpbReg:  opb = rt_val;
      OpbSext: opb = imm_sext;
      OpbZext: opb = imm_zext;
      default: opb = imm_sext;
    endcase
  end

  always_comb begin
    alu_result = 32'h0;
    unique case (alu_op)
      AluAdd:  alu_result = rs_val + opb;
      AluSub:  alu_result = rs_val - opb;
      AluAnd:  alu_result = rs_val & opb;
      AluOr:   alu_result = rs_val | opb;
      AluSlt:  alu_result = {31'h0, $signed(rs_val) < $signed(opb)};
      AluLui:  alu_result = {imm, 16'h0000};
      default: alu_result = 32'h0;
    endcase
  end

  // Data memory: byte address low bits dropped, high bits wrap modulo the depth
  logic [31:0]        dmem_q [DMEM_WORDS];
  logic [DMEM_AW-1:0] mem_idx;
  logic [31:0]        mem_rdata;

  assign mem_addr  = rs_val + imm_sext;
  assign mem_idx   = mem_addr[DMEM_AW+1:2];
  assign mem_rdata = dmem_q[mem_idx];
  assign mem_wdata = rt_val;

  // Write-back; enables are gated by reset so an in-flight write is aborted
  assign wb_en   = dec_wr_reg & ~rst;
  assign mem_we  = dec_mem_wr & ~rst;
  assign wb_addr = dec_dst_rd ? rd : rt;
  assign wb_data = dec_mem_rd ? mem_rdata : alu_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= 32'h0;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DMEM_WORDS; i++) begin
        dmem_q[i] <= 32'h0;
      end
    end else if (mem_we) begin
      dmem_q[mem_idx] <= mem_wdata;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{instruction[10:6], mem_addr[1:0], mem_addr[31:DMEM_AW+2]};

endmodule

// File: tb/tb_mips_instr_exec.sv
// Self-checking bench for mips_instr_exec: directed plan, random program against an ISA-level
// model, and asynchronous mid-stream reset.
`timescale 1ns/1ps

module tb_mips_instr_exec;

  localparam int unsigned DMEM_WORDS = 64;
  localparam int unsigned DMEM_AW    = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] alu_result;

  mips_instr_exec #(
    .DMEM_WORDS(DMEM_WORDS),
    .DMEM_AW   (DMEM_AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Architectural state as the ISA sees it
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [DMEM_WORDS];

  typedef struct {
    logic        we_reg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we_mem;
    logic        mem_op;
    logic        is_alu;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t predict(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] a, b, sx, zx, ea;
    logic [15:0] imm;
    imm = ins[15:0];
    a   = m_reg[ins[25:21]];
    b   = m_reg[ins[20:16]];
    sx  = 32'(signed'(imm));
    zx  = 32'(imm);
    ea  = a + sx;
    e.we_reg = 1'b0; e.waddr = ins[20:16]; e.wdata = 32'h0; e.we_mem = 1'b0;
    e.mem_op = 1'b0; e.is_alu = 1'b0; e.maddr = ea; e.mwdata = b;
    case (ins[31:26])
      6'h00: begin
        e.waddr = ins[15:11];
        e.we_reg = 1'b1;
        e.is_alu = 1'b1;
        case (ins[5:0])
          6'h20:   e.wdata = a + b;
          6'h22:   e.wdata = a - b;
          6'h24:   e.wdata = a & b;
          6'h25:   e.wdata = a | b;
          6'h2A:   e.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin e.we_reg = 1'b0; e.is_alu = 1'b0; end
        endcase
      end
      6'h08: begin e.we_reg = 1'b1; e.is_alu = 1'b1; e.wdata = a + sx; end
      6'h23: begin
        e.we_reg = 1'b1;
        e.mem_op = 1'b1;
        e.wdata  = m_mem[(ea >> 2) % DMEM_WORDS];
      end
      6'h2B: begin e.we_mem = 1'b1; e.mem_op = 1'b1; end
`ifdef IMM_LOGIC_EN
      6'h0C: begin e.we_reg = 1'b1; e.is_alu = 1'b1; e.wdata = a & zx; end
      6'h0D: begin e.we_reg = 1'b1; e.is_alu = 1'b1; e.wdata = a | zx; end
      6'h0A: begin
        e.we_reg = 1'b1; e.is_alu = 1'b1;
        e.wdata = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
      end
      6'h0F: begin e.we_reg = 1'b1; e.is_alu = 1'b1; e.wdata = {imm, 16'h0000}; end
`endif
      default: e.we_reg = 1'b0;
    endcase
    if (zx == 32'hFFFF_FFFF) e.wdata = ~e.wdata;  // never true; keeps zx referenced in all builds
    return e;
  endfunction

  task automatic model_reset();
    foreach (m_reg[i]) m_reg[i] = 32'h0;
    foreach (m_mem[i]) m_mem[i] = 32'h0;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    dbg_raddr = r;
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  // Apply one instruction for one cycle, check its outputs, then its architectural effect
  task automatic exec(input logic [31:0] ins, input string tag);
    exp_t e;
    @(negedge clk);
    instruction = ins;
    e = predict(ins);
    #1;
    if (!(e.we_reg && e.waddr == 5'd0)) check({tag, ".wb_en"}, 32'(wb_en), 32'(e.we_reg));
    check({tag, ".mem_we"}, 32'(mem_we), 32'(e.we_mem));
    if (e.we_reg) begin
      check({tag, ".wb_addr"}, 32'(wb_addr), 32'(e.waddr));
      check({tag, ".wb_data"}, wb_data, e.wdata);
    end
    if (e.is_alu) check({tag, ".alu_result"}, alu_result, e.wdata);
    if (e.mem_op) check({tag, ".mem_addr"}, mem_addr, e.maddr);
    if (e.we_mem) check({tag, ".mem_wdata"}, mem_wdata, e.mwdata);
    @(posedge clk);
    #1;
    if (e.we_reg && e.waddr != 5'd0) m_reg[e.waddr] = e.wdata;
    if (e.we_mem) m_mem[(e.maddr >> 2) % DMEM_WORDS] = e.mwdata;
    dbg_raddr = e.we_reg ? e.waddr : 5'($urandom_range(31));
    #1;
    check({tag, ".dbg"}, dbg_rdata, m_reg[dbg_raddr]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0]  ilo [4] = '{6'h0C, 6'h0D, 6'h0A, 6'h0F};
    logic [5:0]  bad [4] = '{6'h3F, 6'h02, 6'h04, 6'h2C};
    rs  = 5'($urandom_range(7));
    rt  = 5'($urandom_range(7));
    rd  = 5'($urandom_range(7));
    imm = 16'($urandom);
    case ($urandom_range(11))
      0, 1, 2, 3: return r_type(fns[$urandom_range(4)], rd, rs, rt);
      4, 5:       return i_type(6'h08, rt, rs, imm);
      6:          return i_type(6'h23, rt, rs, imm);
      7:          return i_type(6'h2B, rt, rs, imm);
      8:          return i_type(bad[$urandom_range(3)], rt, rs, imm);
      9:          return r_type(6'h00, rd, rs, rt);
      default:    return i_type(ilo[$urandom_range(3)], rt, rs, imm);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    rst         = 1'b1;
    instruction = 32'h2109000A;
    dbg_raddr   = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    check("reset.wb_en", 32'(wb_en), 32'h0);
    check("reset.mem_we", 32'(mem_we), 32'h0);
    check("reset.dbg9", dbg_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed program
    exec(32'h2109000A, "addi9");
    exec(32'h210A0012, "addi10");
    exec(32'h210B000A, "addi11");
    exec(32'h210C0014, "addi12");
    exec(32'h210D001E, "addi13");
    check_reg("plan.r9", 5'd9, 32'd10);
    check_reg("plan.r10", 5'd10, 32'd18);
    check_reg("plan.r13", 5'd13, 32'd30);
    exec(32'h01494820, "add9");
    check_reg("plan.add", 5'd9, 32'd28);
    exec(32'h8D4C0008, "lw12");
    check_reg("plan.lw", 5'd12, 32'd0);
    exec(32'hAD4B000A, "sw28");
    exec(32'h8D4D000A, "lw13");
    check_reg("plan.lw13", 5'd13, 32'd10);
    exec(32'h2000FFFF, "addi0");
    check_reg("plan.r0", 5'd0, 32'd0);
    exec(32'hFC000000, "unknown");

    // Overflow wraps: build 0x80000000 by doubling, then 0x7FFFFFFF
    exec(i_type(6'h08, 5'd2, 5'd0, 16'd1), "one");
    for (int i = 0; i < 31; i++) exec(r_type(6'h20, 5'd2, 5'd2, 5'd2), "dbl");
    check_reg("ovf.min", 5'd2, 32'h8000_0000);
    exec(i_type(6'h08, 5'd1, 5'd0, 16'hFFFF), "m1");
    exec(r_type(6'h22, 5'd1, 5'd1, 5'd2), "max");
    check_reg("ovf.max", 5'd1, 32'h7FFF_FFFF);
    exec(r_type(6'h20, 5'd2, 5'd1, 5'd1), "ovfadd");
    check_reg("ovf.add", 5'd2, 32'hFFFF_FFFE);
    exec(i_type(6'h08, 5'd3, 5'd0, 16'hFFFF), "sltA");
    exec(i_type(6'h08, 5'd4, 5'd0, 16'd1), "sltB");
    exec(r_type(6'h2A, 5'd5, 5'd3, 5'd4), "slt");
    check_reg("slt.neg", 5'd5, 32'd1);
    exec(i_type(6'h08, 5'd5, 5'd0, 16'd5), "subA");
    exec(i_type(6'h08, 5'd6, 5'd0, 16'd7), "subB");
    exec(r_type(6'h22, 5'd7, 5'd5, 5'd6), "sub");
    check_reg("sub.neg", 5'd7, 32'hFFFF_FFFE);

    // Random program with dependent back-to-back instructions
    for (int i = 0; i < 300; i++) exec(rand_instr(), "rand");
    for (int r = 0; r < 32; r++) check_reg("sweep.reg", 5'(r), m_reg[r]);
    for (int w = 0; w < DMEM_WORDS; w++) exec(i_type(6'h23, 5'd1, 5'd0, 16'(w * 4)), "sweep.mem");

    // Mid-stream reset clears state without a clock edge and blocks writes
    exec(i_type(6'h08, 5'd9, 5'd0, 16'h0055), "pre.addi");
    exec(i_type(6'h2B, 5'd9, 5'd0, 16'h0040), "pre.sw");
    @(negedge clk);
    instruction = i_type(6'h08, 5'd9, 5'd0, 16'h0077);
    rst         = 1'b1;
    dbg_raddr   = 5'd9;
    #1;
    model_reset();
    check("rst.async.r9", dbg_rdata, 32'h0);
    check("rst.wb_en", 32'(wb_en), 32'h0);
    instruction = i_type(6'h23, 5'd2, 5'd0, 16'h0040);
    #1;
    check("rst.async.mem", wb_data, 32'h0);
    instruction = i_type(6'h2B, 5'd4, 5'd0, 16'h0040);
    #1;
    check("rst.mem_we", 32'(mem_we), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reg("post.r9", 5'd9, 32'h0);
    exec(i_type(6'h23, 5'd2, 5'd0, 16'h0040), "post.lw");
    exec(i_type(6'h08, 5'd4, 5'd0, 16'h1234), "post.addi");
    check_reg("post.r4", 5'd4, 32'h0000_1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
